// File: rtl/i2s_stream_tx_pkg.sv
// rtl/i2s_stream_tx_pkg.sv - shared state type and constants for the I2S stream transmitter
`timescale 1ns/1ps
package i2s_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        RUN
    } i2s_tx_state_t;

endpackage

// File: rtl/i2s_stream_tx_if.sv
// rtl/i2s_stream_tx_if.sv - stereo sample frame stream (valid/ready) into the I2S transmitter
`timescale 1ns/1ps
interface i2s_stream_tx_if #(
    parameter int SAMPLE_W = 16
) ();

    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_left;
    logic [SAMPLE_W-1:0] in_right;

    modport master (
        output in_valid,
        output in_left,
        output in_right,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_left,
        input  in_right,
        output in_ready
    );

endinterface

// File: rtl/i2s_frame_fifo.sv
// rtl/i2s_frame_fifo.sv - synchronous FIFO of {left,right} frames with full/empty/level
`timescale 1ns/1ps
module i2s_frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // full is taken from the registered count, so a pop in the same cycle never frees room early
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/i2s_stream_tx.sv
// rtl/i2s_stream_tx.sv - I2S transmitter; I2S_TX_UNDERRUN_HOLD_EN repeats the last frame on underrun
`timescale 1ns/1ps
module i2s_stream_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int LEVEL_W   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Enable,
    i2s_stream_tx_if.slave     stream,
    input  logic               SCLK,
    input  logic               LRCLK,
    output logic               SDOUT,
    output logic               underrun,
    input  logic               clear_underrun,
    output logic [LEVEL_W-1:0] fill_level
);

    if (SAMPLE_W < 1 || SAMPLE_W > SLOT_W) begin : g_bad_sample_w
        $error("i2s_stream_tx: SAMPLE_W must be in 1..SLOT_W");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("i2s_stream_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } frame_t;

    i2s_tx_state_t          state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync, lr_sync;
    logic                   sclk_d, sclk_s, lr_s, sclk_fall;
    logic                   lr_prev;
    logic [SLOT_W-1:0]      shreg;
    frame_t                 hold, fifo_head, left_src, underrun_frame;
    logic                   slot_step, left_start, right_start;
    logic                   load_left, load_right, pop, underrun_evt;
    logic                   fifo_full, fifo_empty;
    logic [2*SAMPLE_W-1:0]  fifo_rdata;

    function automatic logic [SLOT_W-1:0] pad(input logic [SAMPLE_W-1:0] s);
        return SLOT_W'(s) << (SLOT_W - SAMPLE_W);
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sclk_sync <= '0;
            sclk_d    <= 1'b0;
            lr_sync   <= '1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            sclk_d    <= sclk_s;
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], LRCLK};
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign lr_s        = lr_sync[SYNC_STAGES-1];
    assign sclk_fall   = sclk_d && !sclk_s;
    assign left_start  = !lr_s && lr_prev;
    assign right_start = lr_s && !lr_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        slot_step = 1'b0;
        case (state_q)
            IDLE:    if (Enable) state_d = ALIGN;
            ALIGN: begin
                if (sclk_fall && left_start) begin
                    state_d   = RUN;
                    slot_step = 1'b1;
                end
            end
            RUN:     slot_step = sclk_fall;
            default: state_d = IDLE;
        endcase
        if (!Enable) begin
            state_d   = IDLE;
            slot_step = 1'b0;
        end
    end

    assign load_left    = slot_step && left_start;
    assign load_right   = slot_step && right_start;
    assign pop          = load_left && !fifo_empty;
    assign underrun_evt = load_left && fifo_empty;
    assign fifo_head    = frame_t'(fifo_rdata);

`ifdef I2S_TX_UNDERRUN_HOLD_EN
    assign underrun_frame = hold;
`else
    assign underrun_frame = '0;
`endif

    assign left_src = pop ? fifo_head : underrun_frame;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            SDOUT    <= 1'b0;
            shreg    <= '0;
            lr_prev  <= 1'b1;
            hold     <= '0;
            underrun <= 1'b0;
        end else begin
            // lr_prev tracks LRCLK even while idle so ALIGN never sees a stale left edge
            if (sclk_fall) lr_prev <= lr_s;
            if (state_q == IDLE) begin
                SDOUT <= 1'b0;
                shreg <= '0;
            end else if (slot_step) begin
                SDOUT <= shreg[SLOT_W-1];
                if (load_left)       shreg <= pad(left_src.left);
                else if (load_right) shreg <= pad(hold.right);
                else                 shreg <= shreg << 1;
            end
            if (load_left) hold <= left_src;
            if (underrun_evt)        underrun <= 1'b1;
            else if (clear_underrun) underrun <= 1'b0;
        end
    end

    i2s_frame_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (stream.in_valid),
        .wdata ({stream.in_left, stream.in_right}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fill_level)
    );

    assign stream.in_ready = !fifo_full;

endmodule
